surf_cmd_tx: RTL
================

# surf_cmd_tx

TURF-side serial command transmitter: the sending end of the single-line CMD link that each SURF receives through its clock/IO infrastructure and decodes in the register block. It accepts command words over a valid/ready handshake, frames each one with a start bit and even parity, and shifts it out MSB-first at a programmable bit rate. Between frames it enforces a minimum idle gap. It is used in the TURF firmware and in the SURF bench as the CMD stimulus source.

## Interface
Parameters:
- CMD_WIDTH, 32, command payload bits per frame (≥ 2).
- CLKS_PER_BIT, 1, clk_i cycles per serial bit (≥ 1).
- IDLE_BITS, 2, minimum idle bit-times after each frame (≥ 1).

Ports:
- clk_i  in  1  system clock (33 MHz domain).
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_dat_i  in  CMD_WIDTH  command word to send.
- cmd_valid_i  in  1  cmd_dat_i is valid.
- cmd_ready_o  out  1  block can accept a word; registered.
- cmd_o  out  1  serial CMD line (single-ended, before the LVDS buffer); registered; idle level 0.
- busy_o  out  1  a frame or idle gap is in progress; registered.
- sent_o  out  1  one-cycle pulse when a frame's parity bit has finished.
- frame_cnt_o  out  16  count of completed frames, wraps.

## Operation
- Frame on cmd_o: 1 start bit (=1), CMD_WIDTH data bits MSB-first, 1 parity bit, then IDLE_BITS gap bits (=0).
- Parity bit = XOR of all data bits (even parity over the data bits).
- The block captures cmd_dat_i into a shift register on the clk_i edge where cmd_valid_i & cmd_ready_o. Later changes to cmd_dat_i do not affect the frame.
- States:
  - IDLE: cmd_ready_o=1, busy_o=0, cmd_o=0. On accept → START.
  - START: cmd_o=1.
  - DATA: cmd_o=shift MSB. Shift occurs every CLKS_PER_BIT cycles. A bit counter tracks CMD_WIDTH bits.
  - PARITY: cmd_o=parity.
  - GAP: cmd_o=0, lasts IDLE_BITS bit-times. → IDLE.
- Each state lasts exactly CLKS_PER_BIT cycles per bit. A prescaler counter reloads at every bit boundary.
- cmd_ready_o=1 only in IDLE. There is no back-to-back accept during GAP.
- On PARITY→GAP:
  - sent_o pulses high for 1 cycle, coincident with the first GAP cycle.
  - frame_cnt_o increments, mod 2^16 (0xFFFF→0x0000).
- cmd_valid_i outside IDLE is ignored. The word is held by the upstream until ready.
- Reset values: cmd_ready_o=1, cmd_o=0, busy_o=0, sent_o=0, frame_cnt_o=0, state IDLE, shift register 0.
- Reset mid-frame:
  - cmd_o drops to 0 immediately, asynchronously.
  - The frame is discarded and frame_cnt_o clears.
  - sent_o is not pulsed.
  - The receiver sees a truncated frame and must resync on the next start bit after ≥ IDLE_BITS zeros. The first post-reset accept is allowed on the first edge after rst_i deasserts.

## Timing
- Define accept edge = clk_i edge k where cmd_valid_i & cmd_ready_o.
- Let B = CLKS_PER_BIT and N = 1+CMD_WIDTH+1+IDLE_BITS.
- Start bit occupies cycles k+1 … k+B.
- Data bit i (i=0 is the MSB) occupies cycles k+1+(1+i)·B … k+(2+i)·B.
- Parity occupies cycles k+1+(1+CMD_WIDTH)·B … k+(2+CMD_WIDTH)·B.
- sent_o is high in cycle k+1+(2+CMD_WIDTH)·B.
- cmd_ready_o returns to 1 in cycle k+1+N·B. The earliest next accept edge is k+1+N·B.
- Sustained throughput is one frame per N·B cycles. With the defaults this is 36 cycles per frame.
- busy_o = NOT cmd_ready_o, i.e. high for cycles k+1 … k+N·B.

## Test plan
- Reset, then idle 10 cycles → cmd_ready_o=1, cmd_o=0, busy_o=0, frame_cnt_o=0x0000.
- Defaults, send 0x80000001 at edge k:
  - cmd_o sequence from k+1 is 1, 1, 30×0, 1, parity 0, 0, 0.
  - sent_o is high at k+35.
  - cmd_ready_o returns at k+37.
  - frame_cnt_o=1.
- Defaults, send 0x00000007 → parity bit = 1. Data bits are 29×0 then 1,1,1.
- CLKS_PER_BIT=3, send 0xA5A5A5A5:
  - Each bit holds for exactly 3 cycles.
  - Frame plus gap spans 108 cycles.
  - Parity = 0.
- cmd_valid_i held high with changing data during a frame → only the captured word is sent. The next word is accepted exactly at k+37 (defaults).
- Assert rst_i during data bit 10 → cmd_o=0 in the same cycle and frame_cnt_o=0. A new frame started after release is transmitted cleanly.
- Preload frame_cnt_o via 65536 frames (or a force) → it wraps 0xFFFF→0x0000 on the next sent_o.

Source files
------------

// File: rtl/surf_cmd_tx.sv
// surf_cmd_tx - serial CMD link transmitter (TURF side).
//
// Accepts a command word on a valid/ready handshake and sends it on cmd_o as
//   start(1) | CMD_WIDTH data bits MSB-first | even parity | IDLE_BITS zeros
// Each bit lasts CLKS_PER_BIT clocks. The next word is accepted only after
// the idle gap, so the receiver always sees at least IDLE_BITS zeros.
//
// Ports
//   clk_i        system clock
//   rst_i        async active-high reset; cmd_o drops to 0 at once
//   cmd_dat_i    command word, captured on the accept edge
//   cmd_valid_i  cmd_dat_i valid (ignored while not ready)
//   cmd_ready_o  high only in IDLE (registered)
//   cmd_o        serial CMD line, idle 0 (registered)
//   busy_o       frame or gap in progress, == ~cmd_ready_o (registered)
//   sent_o       1-cycle pulse in the first gap cycle
//   frame_cnt_o  completed frames, wraps at 2^16
module surf_cmd_tx #(
  parameter int CMD_WIDTH    = 32,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_BITS    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CMD_WIDTH-1:0] cmd_dat_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic                 cmd_o,
  output logic                 busy_o,
  output logic                 sent_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int PW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BMAX = (CMD_WIDTH > IDLE_BITS) ? CMD_WIDTH : IDLE_BITS;
  localparam int BW   = $clog2(BMAX);
  localparam logic [PW-1:0] PRE_LOAD = PW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [CMD_WIDTH-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   cmd_q, cmd_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   sent_q, sent_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   bit_end;

  // Last clock of the current bit-time.
  assign bit_end = (pre_q == '0);

  always_comb begin
    state_d     = state_q;
    pre_d       = bit_end ? PRE_LOAD : pre_q - PW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    cmd_d       = cmd_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    sent_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        pre_d = PRE_LOAD;
        if (cmd_valid_i && ready_q) begin
          shift_d = cmd_dat_i;
          par_d   = ^cmd_dat_i;
          state_d = S_START;
          cmd_d   = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        cmd_d   = shift_q[CMD_WIDTH-1];
        bit_d   = BW'(CMD_WIDTH - 1);
      end
      S_DATA: if (bit_end) begin
        if (bit_q == '0) begin
          state_d = S_PARITY;
          cmd_d   = par_q;
        end else begin
          // The MSB is already on the line; shift and present the next bit.
          shift_d = shift_q << 1;
          cmd_d   = shift_q[CMD_WIDTH-2];
          bit_d   = bit_q - BW'(1);
        end
      end
      S_PARITY: if (bit_end) begin
        state_d     = S_GAP;
        cmd_d       = 1'b0;
        sent_d      = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        bit_d       = BW'(IDLE_BITS - 1);
      end
      S_GAP: if (bit_end) begin
        if (bit_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cmd_d   = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      cmd_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      cmd_q       <= cmd_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign cmd_o       = cmd_q;
  assign busy_o      = busy_q;
  assign sent_o      = sent_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
